mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the fetch stage (I-side) and the memory stage (D-side) of the xgriscv pipeline.
- Sequences each transaction through a small FSM and raises a per-side stall until the memory acknowledges.
- Times out hung transactions with a watchdog.
- Sits between the CPU core and the unified instruction/data memory.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 15, watchdog limit in cycles from m_req rise; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data, valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse to fetch
- i_stall  out  1  i_req & ~i_ack
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  write enable
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  load data, valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse to data side
- d_stall  out  1  d_req & ~d_ack
- m_req  out  1  memory request, registered
- m_we  out  1  registered write enable
- m_be  out  DW/8  registered byte enables
- m_addr  out  AW  registered address
- m_wdata  out  DW  registered write data
- m_rdata  in  DW  memory read data, valid with m_ack
- m_ack  in  1  one-cycle memory completion pulse, only while m_req=1
- owner  out  2  current grant: 00 none, 01 I, 10 D
- err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rstn=0): state IDLE; owner=00; m_req=0; m_we=0; m_be=0; m_addr=0; m_wdata=0; err=0; watchdog counter=0.
- Reset mid-transaction: abandons the transaction immediately. No ack is issued.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE with any request pending: pick a winner; at the next edge load the winner's addr/we/be/wdata into m_*, set m_req=1, go to BUSY_x. Minimum latency is request at cycle 0 -> m_req at cycle 1.
- I-side grants drive m_we=0, m_be=all ones, m_wdata=0.
- Fixed priority (default): D beats I when both are pending.
- BUSY_x with m_ack=1: x_ack=1 combinationally in the same cycle; x_rdata=m_rdata. The other side's ack stays 0 and its rdata holds its last value.
- Back-to-back: on the ack cycle, the acked side is excluded from arbitration for that cycle only.
  - If the other side is requesting, its transaction is loaded at the same edge. m_req stays 1 with new contents and the state changes directly.
  - Otherwise go to IDLE with m_req=0.
- While BUSY, m_* registers are frozen. Requester input changes are ignored until ack.
- Watchdog: counter clears on every grant and increments each BUSY cycle without m_ack. When it reaches MAX_WAIT:
  - x_ack=1, x_rdata=0, err=1 for one cycle;
  - m_req drops at the next edge;
  - return to IDLE.
- A late m_ack arriving after an abort is ignored.
- m_ack while IDLE is ignored.
- owner reflects the state register.
- Stall outputs are combinational.

Optional Feature:
- Macro: MEM_BUS_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-served register (reset = I) gives the next simultaneous conflict to the side not served last.
- Undefined: fixed D-over-I priority; no last-served register.

Decomposition:
- Package mem_bus_arb_pkg holds:
  - owner encodings OWN_NONE=2'b00, OWN_I=2'b01, OWN_D=2'b10;
  - state encodings S_IDLE, S_BUSY_I, S_BUSY_D;
  - width of the watchdog counter, computed from MAX_WAIT.
- One sub-module, mem_bus_arb_wdog: a clearable saturating counter with a timeout output. The FSM, mux and picker stay in the top level.

Test Plan:
- After reset: all outputs 0. i_req=1, i_addr=0x00000004, memory acks 2 cycles after m_req -> m_req rises at cycle 1 with m_addr=0x4 and m_we=0; i_ack pulses at cycle 3 with i_rdata=m_rdata=0x00500093.
- i_req and d_req rise together, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF -> D served first; I granted on D's ack edge with no m_req gap; i_stall=1 throughout.
- Round-robin build with both requests held continuously for 4 transactions -> grant order D, I, D, I. Fixed-priority build, with d_req re-raised immediately after each of its acks -> same order, because of the one-cycle exclusion.
- MAX_WAIT=15, memory never acks a D load -> d_ack=1, d_rdata=0, err=1 exactly 15 cycles after m_req rose; m_req=0 next cycle; owner=00; a late m_ack is ignored.
- rstn pulled low while BUSY_D with m_req=1 -> m_req and owner drop immediately, before the next clock edge; no d_ack is issued; after release a fresh d_req completes normally.
- m_ack pulsed while IDLE, no requests pending -> no ack pulses; owner stays 00; m_req stays 0.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings for the I/D memory bus arbiter.
// Optional round-robin arbitration is enabled with MEM_BUS_ARB_RR_EN.
package mem_bus_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // State codes double as the owner encoding.
  typedef enum logic [1:0] {
    S_IDLE   = OWN_NONE,
    S_BUSY_I = OWN_I,
    S_BUSY_D = OWN_D
  } state_e;

  function automatic int unsigned wdog_w(input int unsigned max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arb_wdog.sv
// Clearable saturating cycle counter with a timeout flag.
// A LIMIT of zero never times out.
module mem_bus_arb_wdog
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned CW    = wdog_w(LIMIT)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (LIMIT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (I) and memory (D) stages.
// Define MEM_BUS_ARB_RR_EN for round-robin instead of D-over-I.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            d_stall,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic [1:0]      owner,
  output logic            err
);

  state_e          state_q;
  logic            m_req_q;
  logic            m_we_q;
  logic [DW/8-1:0] m_be_q;
  logic [AW-1:0]   m_addr_q;
  logic [DW-1:0]   m_wdata_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic busy, hit, abort, done, wd_to;
  logic cand_i, cand_d, pick_i, pick_d;
  logic can_grant, grant;

  assign busy  = (state_q != S_IDLE);
  assign hit   = busy & m_ack;
  assign abort = busy & ~m_ack & wd_to;
  assign done  = hit | abort;

  // The side being acked sits out this cycle's arbitration.
  assign cand_i    = i_req & (state_q != S_BUSY_I);
  assign cand_d    = d_req & (state_q != S_BUSY_D);
  assign can_grant = ~busy | hit;

`ifdef MEM_BUS_ARB_RR_EN
  logic last_d_q;

  assign pick_d = cand_d & (~cand_i | ~last_d_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_d_q <= 1'b0;
    end else if (grant) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = cand_d;
`endif

  assign pick_i = cand_i & ~pick_d;
  assign grant  = can_grant & (pick_i | pick_d);

  mem_bus_arb_wdog #(
    .LIMIT (MAX_WAIT),
    .CW    (wdog_w(MAX_WAIT))
  ) u_wdog (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (grant | ~busy),
    .inc_i     (busy & ~m_ack),
    .timeout_o (wd_to)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant) begin
        state_q   <= pick_d ? S_BUSY_D : S_BUSY_I;
        m_req_q   <= 1'b1;
        m_we_q    <= pick_d & d_we;
        m_be_q    <= pick_d ? d_be : '1;
        m_addr_q  <= pick_d ? d_addr : i_addr;
        m_wdata_q <= pick_d ? d_wdata : '0;
      end else if (done) begin
        state_q <= S_IDLE;
        m_req_q <= 1'b0;
      end
      if (i_ack) begin
        i_rdata_q <= i_rdata;
      end
      if (d_ack) begin
        d_rdata_q <= d_rdata;
      end
    end
  end

  assign i_ack   = (state_q == S_BUSY_I) & done;
  assign d_ack   = (state_q == S_BUSY_D) & done;
  assign i_rdata = i_ack ? (abort ? '0 : m_rdata) : i_rdata_q;
  assign d_rdata = d_ack ? (abort ? '0 : m_rdata) : d_rdata_q;
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;
  assign err     = abort;
  assign owner   = state_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against
// a transaction-level memory and requester model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack, i_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_stall;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic [1:0]  owner;
  logic        err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_ack(i_ack), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .owner(owner), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int mcnt = 0;
  int mem_lat = 1;
  bit mem_en = 1'b1;
  bit mem_act = 1'b0;
  bit force_ack = 1'b0;
  bit rnd_lat = 1'b0;
  logic [31:0] phys [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int ord [$];
  int exp_ord [4] = '{2, 1, 2, 1};
  int nd, ni, got, ntx, age_i, age_d;
  bit sd, si, early, pend_i, pend_d;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] prd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : fill(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] w, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) o[8*b +: 8] = w[8*b +: 8];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
      input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and run the memory responder for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_req && mem_act) mcnt++;
    else mcnt = 0;
    if (mcnt == 0 && rnd_lat) mem_lat = $urandom_range(0, 3);
    m_ack = force_ack || (mem_en && m_req && mcnt == mem_lat);
    if (m_ack && m_req && m_we)
      phys[m_addr] = merge(prd(m_addr), m_wdata, m_be);
    m_rdata = (m_ack && !m_we) ? prd(m_addr) : $urandom();
    mem_act = m_req && !m_ack;
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; d_we = 0; force_ack = 0;
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    phys[32'h4] = 32'h00500093;
    ref_mem[32'h4] = 32'h00500093;
    #1 rstn = 0;
    @(negedge clk);
    chk("rst_mbus", {m_req, m_we, m_be, owner, err}, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mwdata", m_wdata, 0);
    chk("rst_acks", {i_ack, d_ack, i_stall, d_stall}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    tick();
    rstn = 1;

    // single fetch, memory latency 2
    mem_lat = 2;
    tick();
    i_req = 1; i_addr = 32'h4;
    @(negedge clk);
    chk("t1_c0", {m_req, i_stall}, 2'b01);
    tick(); @(negedge clk);
    chk("t1_c1_req", {m_req, m_we, m_be, owner}, {1'b1, 1'b0, 4'hF, 2'b01});
    chk("t1_c1_addr", m_addr, 32'h4);
    tick(); @(negedge clk);
    chk("t1_c2_ack", i_ack, 0);
    tick(); @(negedge clk);
    chk("t1_c3_ack", {i_ack, i_stall}, 2'b10);
    chk("t1_c3_data", i_rdata, 32'h00500093);
    tick();
    i_req = 0;
    @(negedge clk);
    chk("t1_c4", {m_req, owner, i_ack}, 0);
    chk("t1_hold", i_rdata, 32'h00500093);

    // simultaneous requests: D store first, I follows with no gap
    mem_lat = 1;
    tick();
    i_req = 1; i_addr = 32'h8;
    d_req = 1; d_we = 1; d_addr = 32'h100;
    d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    @(negedge clk);
    chk("t2_c0", {i_stall, d_stall, m_req}, 3'b110);
    tick(); @(negedge clk);
    chk("t2_c1_own", {owner, m_we, m_be, i_stall}, {2'b10, 1'b1, 4'hF, 1'b1});
    chk("t2_c1_addr", m_addr, 32'h100);
    chk("t2_c1_wdata", m_wdata, 32'hDEADBEEF);
    tick(); @(negedge clk);
    chk("t2_c2_ack", {d_ack, i_ack, i_stall, d_stall}, 4'b1010);
    ref_mem[32'h100] = merge(ref_rd(32'h100), 32'hDEADBEEF, 4'hF);
    tick();
    d_req = 0; d_we = 0;
    @(negedge clk);
    chk("t2_c3_own", {m_req, owner, m_we, m_be, i_stall},
        {1'b1, 2'b01, 1'b0, 4'hF, 1'b1});
    chk("t2_c3_addr", m_addr, 32'h8);
    chk("t2_c3_wdata", m_wdata, 0);
    tick(); @(negedge clk);
    chk("t2_c4_ack", i_ack, 1);
    chk("t2_c4_data", i_rdata, ref_rd(32'h8));
    tick();
    i_req = 0;

    // both sides keep requesting: grants alternate D, I, D, I
    nd = 0; ni = 0;
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h300;
    i_req = 1; i_addr = 32'h340;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sd = d_ack; si = i_ack;
      if (sd) ord.push_back(2);
      if (si) ord.push_back(1);
      tick();
      if (sd) begin nd++; d_addr += 4; if (nd >= 2) d_req = 0; end
      if (si) begin ni++; i_addr += 4; if (ni >= 2) i_req = 0; end
      if (nd >= 2 && ni >= 2) break;
    end
    i_req = 0; d_req = 0;
    chk("t3_len", ord.size(), 4);
    for (int k = 0; k < 4; k++) begin
      got = (k < ord.size()) ? ord[k] : 0;
      chk($sformatf("t3_ord%0d", k), got, exp_ord[k]);
    end
    tick(); @(negedge clk);
    chk("t3_idle", {m_req, owner}, 0);

    // watchdog: D load never acked
    mem_en = 0;
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    early = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) chk("t4_mreq", {m_req, owner}, 3'b110);
      early |= d_ack | err;
      tick();
    end
    @(negedge clk);
    chk("t4_early", early, 0);
    chk("t4_abort", {d_ack, err, owner}, 4'b1110);
    chk("t4_rdata", d_rdata, 0);
    tick();
    d_req = 0;
    @(negedge clk);
    chk("t4_after", {m_req, owner, err, d_ack}, 0);
    force_ack = 1;
    tick(); @(negedge clk);
    chk("t4_late", {i_ack, d_ack, owner, m_req, err}, 0);
    force_ack = 0;
    mem_en = 1;

    // reset while BUSY_D
    mem_lat = 3;
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h100;
    tick(); @(negedge clk);
    chk("t5_busy", {m_req, owner}, 3'b110);
    #2 rstn = 0;
    #1 chk("t5_async", {m_req, owner, d_ack}, 0);
    tick(); @(negedge clk);
    chk("t5_noack", {d_ack, m_req}, 0);
    tick();
    rstn = 1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_ack) begin got = 1; break; end
      tick();
    end
    chk("t5_done", got, 1);
    chk("t5_data", d_rdata, ref_rd(32'h100));
    tick();
    d_req = 0;

    // m_ack while idle
    tick();
    force_ack = 1;
    tick(); @(negedge clk);
    chk("t6_idle", {i_ack, d_ack, owner, m_req, err}, 0);
    force_ack = 0;

    // randomized traffic
    do_reset();
    rnd_lat = 1;
    pend_i = 0; pend_d = 0; ntx = 0; age_i = 0; age_d = 0;
    for (int c = 0; c < 700; c++) begin
      if (!pend_i && $urandom_range(0, 2) == 0) begin
        pend_i = 1; age_i = 0; i_req = 1;
        i_addr = 32'h300 + 4 * $urandom_range(0, 15);
      end
      if (!pend_d && $urandom_range(0, 2) == 0) begin
        pend_d = 1; age_d = 0; d_req = 1;
        d_we = 1'($urandom_range(0, 1));
        d_be = 4'($urandom_range(1, 15));
        d_wdata = $urandom();
        d_addr = 32'h300 + 4 * $urandom_range(0, 15);
      end
      @(negedge clk);
      if (err) chk("rnd_err", err, 0);
      if (i_ack) begin
        chk("rnd_i_pend", pend_i, 1);
        chk("rnd_i_addr", {m_addr, m_we, m_be}, {i_addr, 1'b0, 4'hF});
        chk("rnd_i_data", i_rdata, ref_rd(i_addr));
        pend_i = 0; ntx++;
      end
      if (d_ack) begin
        chk("rnd_d_pend", pend_d, 1);
        chk("rnd_d_addr", {m_addr, m_we}, {d_addr, d_we});
        if (d_we) ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_be);
        else chk("rnd_d_data", d_rdata, ref_rd(d_addr));
        pend_d = 0; ntx++;
      end
      if (pend_i) age_i++;
      if (pend_d) age_d++;
      if (age_i > 60) begin chk("rnd_i_wait", age_i, 0); break; end
      if (age_d > 60) begin chk("rnd_d_wait", age_d, 0); break; end
      tick();
      if (!pend_i) i_req = 0;
      if (!pend_d) d_req = 0;
    end
    chk("rnd_volume", ntx > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
